muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative RV32M multiply/divide engine with its sequencing FSM; sits beside the EX-stage ALU.
//  Accepts one M-extension op, runs it over XLEN shift iterations, then returns the result.
//  Drives busy so the hazard unit stalls IF/ID/EX.
//  Single clock; reset is synchronous and active-high.
// PARAMETERS
//  XLEN   32  operand/result width; iteration count = XLEN
//  CNT_W  6   iteration counter width, >= clog2(XLEN)+1
// PORTS
//  clk      in   1     clock, all state updates on rising edge
//  reset    in   1     synchronous, active-high reset
//  start    in   1     request; sampled only in IDLE
//  funct3   in   3     RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  rs1      in   XLEN  operand A (dividend/multiplicand), captured with start
//  rs2      in   XLEN  operand B (divisor/multiplier), captured with start
//  flush    in   1     abort in-flight op (branch mispredict/trap)
//  busy     out  1     op in progress (PREP, CALC, FIX)
//  done     out  1     one-cycle pulse, result valid
//  result   out  XLEN  final value; held until next done
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0; counter and internal registers cleared.
//  States:
//  - IDLE: start&!flush -> latch funct3/rs1/rs2, go PREP.
//  - PREP: take abs of signed operands per op; record result sign; counter=0.
//    - Next state CALC, or DONE via early-out (see CONFIGURATION).
//  - CALC: one iteration per cycle.
//    - MUL*: shift-add into a 2*XLEN accumulator.
//    - DIV*/REM*: restoring shift-subtract.
//    - Counter increments; at counter==XLEN-1 go FIX.
//  - FIX: negate per recorded sign; select low word (MUL), high word (MULH*), quotient or remainder.
//    - Register result; go DONE.
//  - DONE: done=1, busy=0; unconditionally IDLE next cycle. start in DONE is ignored.
//  Latency: start accepted at cycle t -> done=1 at t+XLEN+3 (t+35 for XLEN=32).
//  - busy=1 on cycles t+1..t+XLEN+2.
//  Signedness:
//  - MULH: both signed. MULHSU: rs1 signed, rs2 unsigned. MULHU/DIVU/REMU: unsigned.
//  - REM sign follows dividend; DIV sign = sign(rs1)^sign(rs2).
//  Special cases, always architecturally correct:
//  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> rs1.
//  - Signed overflow (rs1=0x80000000, rs2=-1): DIV -> 0x80000000; REM -> 0.
//  flush: any state -> IDLE next cycle; busy=0, done=0; result unchanged.
//  - flush wins over start in the same cycle; a flush during DONE still lets that done pulse stand.
//  start while busy: ignored; latched operands not disturbed.
//  reset mid-operation: immediate return to reset values at next edge.
//  Unknown funct3 is impossible (3 bits fully decoded).
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: PREP goes straight to DONE, skipping CALC/FIX.
//  - Applies to divide-by-zero, signed overflow, or either multiply operand zero.
//  - Result is computed in PREP; done at t+2.
//  MULDIV_EARLY_OUT_EN undefined: every op takes the full t+XLEN+3 latency; special-case values unchanged.
// TESTING
//  1. MUL rs1=7, rs2=-3 (0xFFFFFFFD) -> done at t+35, result=0xFFFFFFEB; busy high 34 cycles.
//  2. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -1*2 -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4. DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//     - Latency t+2 with MULDIV_EARLY_OUT_EN, t+35 without.
//  5. start at t, flush at t+10 -> IDLE at t+11, busy=0, no done, result retains previous value.
//     - New start at t+11 completes normally.
//  6. start pulsed during busy and in DONE -> ignored.
//     - reset at t+20 -> busy=0, done=0, result=0 at t+21.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide engine: one shift-add or restoring shift-subtract step per cycle.
// Optional macro MULDIV_EARLY_OUT_EN lets trivial operations (x/0, signed overflow, multiply by zero) finish from PREP.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div, a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, sdiv_ovf, mul_zero, special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, mul_res, div_res;

  // Operand decode: funct3[2] separates divide from multiply, funct3[0] marks the unsigned divides.
  always_comb begin
    is_div   = f3_q[2];
    a_signed = is_div ? ~f3_q[0] : (f3_q[1:0] == 2'b01 || f3_q[1:0] == 2'b10);
    b_signed = is_div ? ~f3_q[0] : (f3_q[1:0] == 2'b01);
    sign_a   = a_signed & rs1_q[XLEN-1];
    sign_b   = b_signed & rs2_q[XLEN-1];
    mag_a    = sign_a ? -rs1_q : rs1_q;
    mag_b    = sign_b ? -rs2_q : rs2_q;

    div_zero = is_div && (rs2_q == '0);
    sdiv_ovf = is_div && !f3_q[0] && (rs1_q == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_q == '1);
    mul_zero = !is_div && (rs1_q == '0 || rs2_q == '0);
    special  = div_zero || sdiv_ovf || mul_zero;

    if (div_zero)      special_res = f3_q[1] ? rs1_q : '1;
    else if (sdiv_ovf) special_res = f3_q[1] ? '0 : rs1_q;
    else               special_res = '0;
  end

  // One iteration of each algorithm; acc holds {partial high, shifting low operand}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a} : '0);
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    rem_diff = rem_sh - {1'b0, mag_b};

    prod    = neg_q ? -acc_q : acc_q;
    mul_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    quo     = acc_q[XLEN-1:0];
    rem     = acc_q[2*XLEN-1:XLEN];
    if (f3_q[1]) div_res = neg_q ? -rem : rem;
    else         div_res = neg_q ? -quo : quo;
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    state_d  = state_q;
    f3_d     = f3_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d    = funct3;
          rs1_d   = rs1;
          rs2_d   = rs2;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        acc_d   = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
        neg_d   = (is_div && f3_q[1]) ? sign_a : (sign_a ^ sign_b);
        cnt_d   = '0;
        state_d = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
        if (special) begin
          result_d = special_res;
          state_d  = S_DONE;
        end
`endif
      end
      S_CALC: begin
        if (is_div) begin
          if (!rem_diff[XLEN]) acc_d = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                 acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = special ? special_res : (is_div ? div_res : mul_res);
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort beats any request; the operands of a flushed op are simply abandoned.
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops take non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
